// File: rtl/bolme_birimi.sv
// RV32M divider: DIV/DIVU/REM/REMU, restoring division with one quotient bit per cycle.
// Divide-by-zero and signed overflow results are produced directly at acceptance.
module bolme_birimi (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        basla_i,
    input  logic        iptal_i,
    input  logic [1:0]  islem_i,
    input  logic [31:0] bolunen_i,
    input  logic [31:0] bolen_i,
    output logic [31:0] sonuc_o,
    output logic        gecerli_o,
    output logic        mesgul_o
);

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        BITTI   = 2'd2
    } durum_t;

    durum_t      durum_q, durum_d;
    logic [4:0]  sayac_q;
    logic [31:0] bolunen_q, bolen_q, kalan_q, sonuc_q;
    logic        kalan_sec_q, bolum_neg_q, kalan_neg_q;

    logic        isaretli, kalan_sec, sifir_bolen, tasma, ozel, kabul;
    logic [32:0] fark;
    logic [31:0] kalan_d, bolunen_d;

    function automatic logic [31:0] mutlak(input logic signed [31:0] x);
        return x[31] ? 32'(-x) : 32'(x);
    endfunction

    function automatic logic [31:0] isaret_duzelt(input logic signed [31:0] x,
                                                  input logic           neg);
        return neg ? 32'(-x) : 32'(x);
    endfunction

    assign isaretli    = ~islem_i[0];
    assign kalan_sec   = islem_i[1];
    assign sifir_bolen = (bolen_i == 32'd0);
    assign tasma       = isaretli && (bolunen_i == 32'h8000_0000) && (bolen_i == 32'hFFFF_FFFF);
    assign ozel        = sifir_bolen || tasma;
    assign kabul       = (durum_q == BOSTA) && basla_i && !iptal_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) durum_q <= BOSTA;
        else         durum_q <= durum_d;
    end

    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA:   if (kabul) durum_d = ozel ? BITTI : HESAPLA;
            HESAPLA: begin
                if (iptal_i)              durum_d = BOSTA;
                else if (sayac_q == 5'd0) durum_d = BITTI;
            end
            BITTI:   durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    always_comb begin
        gecerli_o = (durum_q == BITTI);
        mesgul_o  = (durum_q != BOSTA);
        sonuc_o   = sonuc_q;
    end

    // Trial subtraction: a non-negative difference yields quotient bit 1, otherwise restore.
    always_comb begin
        fark = {kalan_q, bolunen_q[31]} - {1'b0, bolen_q};
        if (!fark[32]) begin
            kalan_d   = fark[31:0];
            bolunen_d = {bolunen_q[30:0], 1'b1};
        end else begin
            kalan_d   = {kalan_q[30:0], bolunen_q[31]};
            bolunen_d = {bolunen_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sayac_q     <= 5'd0;
            bolunen_q   <= 32'd0;
            bolen_q     <= 32'd0;
            kalan_q     <= 32'd0;
            sonuc_q     <= 32'd0;
            kalan_sec_q <= 1'b0;
            bolum_neg_q <= 1'b0;
            kalan_neg_q <= 1'b0;
        end else if (kabul) begin
            sayac_q     <= 5'd31;
            bolunen_q   <= isaretli ? mutlak(bolunen_i) : bolunen_i;
            bolen_q     <= isaretli ? mutlak(bolen_i)   : bolen_i;
            kalan_q     <= 32'd0;
            kalan_sec_q <= kalan_sec;
            bolum_neg_q <= isaretli && (bolunen_i[31] ^ bolen_i[31]);
            kalan_neg_q <= isaretli && bolunen_i[31];
            if (sifir_bolen)
                sonuc_q <= kalan_sec ? bolunen_i : 32'hFFFF_FFFF;
            else if (tasma)
                sonuc_q <= kalan_sec ? 32'd0 : 32'h8000_0000;
        end else if (durum_q == HESAPLA && !iptal_i) begin
            sayac_q   <= sayac_q - 5'd1;
            bolunen_q <= bolunen_d;
            kalan_q   <= kalan_d;
            if (sayac_q == 5'd0)
                sonuc_q <= kalan_sec_q ? isaret_duzelt(kalan_d, kalan_neg_q)
                                       : isaret_duzelt(bolunen_d, bolum_neg_q);
        end
    end

endmodule

// File: tb/tb_bolme_birimi.sv
// Directed bench for bolme_birimi: arithmetic cases, special results, abort, busy and reset.
module tb_bolme_birimi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        basla = 1'b0;
    logic        iptal = 1'b0;
    logic [1:0]  islem = 2'b00;
    logic [31:0] bolunen = 32'd0;
    logic [31:0] bolen = 32'd0;
    logic [31:0] sonuc;
    logic        gecerli, mesgul;

    int n_chk  = 0;
    int n_fail = 0;

    bolme_birimi dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .basla_i   (basla),
        .iptal_i   (iptal),
        .islem_i   (islem),
        .bolunen_i (bolunen),
        .bolen_i   (bolen),
        .sonuc_o   (sonuc),
        .gecerli_o (gecerli),
        .mesgul_o  (mesgul)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge; cycle 0 is the acceptance cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int cyc;
        cyc = 0;
        islem = op; bolunen = a; bolen = b; basla = 1'b1;
        @(posedge clk); #1;
        basla = 1'b0; bolunen = $urandom; bolen = $urandom; islem = 2'($urandom);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (gecerli) begin
                cyc = k;
                break;
            end
        end
        check({tag, " cycle"}, cyc, exp_cyc);
        check({tag, " sonuc"}, sonuc, exp);
        check({tag, " mesgul"}, {31'd0, mesgul}, 32'd1);
        @(negedge clk);
        check({tag, " tek_gecerli"}, {31'd0, gecerli}, 32'd0);
        check({tag, " bosta"}, {31'd0, mesgul}, 32'd0);
    endtask

    initial begin
        int pulses;
        #1 rst_n = 1'b0;
        #2;
        check("reset sonuc", sonuc, 32'd0);
        check("reset gecerli", {31'd0, gecerli}, 32'd0);
        check("reset mesgul", {31'd0, mesgul}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("DIV 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1);
        run_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("DIVU max/16", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
        run_op("REMU max/16", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);

        // iptal wins over a simultaneous basla in BOSTA
        islem = 2'b01; bolunen = 32'd100; bolen = 32'd7; basla = 1'b1; iptal = 1'b1;
        @(posedge clk); #1;
        basla = 1'b0; iptal = 1'b0;
        @(negedge clk);
        check("priority mesgul", {31'd0, mesgul}, 32'd0);
        check("priority gecerli", {31'd0, gecerli}, 32'd0);

        // basla held through the whole operation
        islem = 2'b01; bolunen = 32'd100; bolen = 32'd7; basla = 1'b1;
        pulses = 0;
        @(posedge clk); #1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (gecerli) pulses++;
            if (k == 33) basla = 1'b0;
        end
        check("held pulses", pulses, 32'd1);
        check("held sonuc", sonuc, 32'd14);

        // abort in cycle 10
        islem = 2'b01; bolunen = 32'd1000; bolen = 32'd3; basla = 1'b1;
        pulses = 0;
        @(posedge clk); #1;
        basla = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (gecerli) pulses++;
        end
        iptal = 1'b1;
        @(posedge clk); #1;
        iptal = 1'b0;
        @(negedge clk);
        check("abort mesgul", {31'd0, mesgul}, 32'd0);
        check("abort gecerli", {31'd0, gecerli | (pulses != 0)}, 32'd0);
        check("abort sonuc", sonuc, 32'd14);
        run_op("after abort DIVU 1000/3", 2'b01, 32'd1000, 32'd3, 32'd333, 33);

        // asynchronous reset in cycle 20
        islem = 2'b01; bolunen = 32'd1000; bolen = 32'd7; basla = 1'b1;
        @(posedge clk); #1;
        basla = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst sonuc", sonuc, 32'd0);
        check("async rst gecerli", {31'd0, gecerli}, 32'd0);
        check("async rst mesgul", {31'd0, mesgul}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gecerli) pulses++;
        end
        check("post rst no gecerli", pulses, 32'd0);
        run_op("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bolme_birimi.md
BOLME_BIRIMI -- requirements
Module: bolme_birimi

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 basla_i  input  1  start request from the execute stage; sampled only in state BOSTA.
REQ-005 iptal_i  input  1  pipeline flush; aborts any operation in progress.
REQ-006 islem_i  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M).
REQ-007 bolunen_i  input  32  dividend (rs1 value).
REQ-008 bolen_i  input  32  divisor (rs2 value).
REQ-009 sonuc_o  output  32  registered result; holds its last value until the next result.
REQ-010 gecerli_o  output  1  result-valid; high for exactly one cycle per completed operation.
REQ-011 mesgul_o  output  1  busy; high whenever state is not BOSTA.

Function
REQ-012 The state machine SHALL have three states: BOSTA, HESAPLA and BITTI.
REQ-013 In BOSTA with basla_i=1 and iptal_i=0, the block SHALL accept the request on that edge and latch islem_i, bolunen_i and bolen_i.
REQ-014 Operand or islem_i changes after acceptance SHALL have no effect on the running operation.
REQ-015 basla_i SHALL be ignored in HESAPLA and BITTI; a request is never queued.
REQ-016 If bolen_i=0 at acceptance, the next state SHALL be BITTI with quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned operations.
REQ-017 If the signed operation has dividend 0x80000000 and divisor 0xFFFFFFFF, the next state SHALL be BITTI with quotient 0x80000000 and remainder 0.
REQ-018 Otherwise the next state SHALL be HESAPLA.
REQ-019 On entry to HESAPLA, a 5-bit counter SHALL be loaded with 31.
REQ-020 For DIV/REM, the operands SHALL be replaced by their absolute values before iterating; for DIVU/REMU they are used unchanged.
REQ-021 HESAPLA SHALL perform one restoring-division step per cycle, using a 33-bit trial subtraction of the divisor from {partial remainder, next dividend bit}.
REQ-022 Each step SHALL shift one quotient bit in, MSB first.
REQ-023 After the step at count 0 (32 steps in total), the next state SHALL be BITTI.
REQ-024 Sign correction SHALL be applied when writing sonuc_o:
  - quotient negated if the signed operand signs differ;
  - remainder takes the dividend's sign;
  - for DIVU/REMU, no sign correction is applied.
REQ-025 sonuc_o SHALL be written with the quotient (DIV/DIVU) or remainder (REM/REMU) on the edge entering BITTI.
REQ-026 gecerli_o SHALL equal (state==BITTI).
REQ-027 BITTI SHALL return to BOSTA on the next edge unconditionally.
REQ-028 Latency, counting the cycle basla_i is accepted as cycle 0:
  - normal operation: gecerli_o high in cycle 33;
  - special cases (REQ-016, REQ-017): gecerli_o high in cycle 1.
REQ-029 iptal_i=1 in HESAPLA SHALL force BOSTA on the next edge; gecerli_o SHALL NOT assert and sonuc_o SHALL be unchanged.
REQ-030 iptal_i=1 in BOSTA SHALL block acceptance; iptal_i has priority over a simultaneous basla_i.
REQ-031 iptal_i=1 in BITTI SHALL NOT suppress that cycle's gecerli_o; the state goes to BOSTA as normal.
REQ-032 The earliest new request after completion SHALL be accepted in the cycle following BITTI.

Reset
REQ-033 While rst_ni=0, regardless of clk_i, the following SHALL hold:
  - state = BOSTA;
  - sonuc_o = 0, gecerli_o = 0, mesgul_o = 0;
  - counter and internal operand and remainder registers = 0.
REQ-034 Reset asserted mid-operation SHALL discard the operation; no gecerli_o SHALL follow the release of rst_ni.
REQ-035 The first request SHALL be accepted on the first rising edge at which rst_ni=1 and basla_i=1.

Verification
REQ-036 The bench SHALL cover these unsigned and signed cases:
  - DIVU 100/7 -> sonuc_o=14, gecerli_o high in cycle 33; REMU 100/7 -> 2.
  - DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-037 The bench SHALL cover these special cases:
  - DIV 5/0 -> 0xFFFFFFFF in cycle 1; REMU 5/0 -> 5; mesgul_o high for exactly 1 cycle.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM of the same operands -> 0.
REQ-038 The bench SHALL cover abort and busy handling:
  - iptal_i pulsed in cycle 10 of DIVU -> no gecerli_o, mesgul_o low in cycle 11, sonuc_o unchanged, new request accepted in cycle 11.
  - basla_i held high during busy -> exactly one result.
REQ-039 The bench SHALL cover reset:
  - rst_ni pulled low asynchronously in cycle 20 -> all outputs 0 immediately, no gecerli_o after release.
  - a DIVU 9/3 issued after release -> 3 in cycle 33.
